switch_debouncer: RTL and testbench

Input-side conditioner for the Basys 3 switch-to-LED demonstration designs. It takes N raw slide-switch levels and synchronises each one to the board clock. It then filters contact bounce with a per-channel counter and state machine, and presents clean levels plus one-cycle rise and fall strobes. The clean levels drive the gate-demonstration logic and the LEDs; the strobes feed later counter and FSM demos.

---
 rtl/switch_debouncer_pkg.sv | 15 +
 rtl/debounce_channel.sv | 118 +++++++++++
 rtl/switch_debouncer.sv | 32 +++
 tb/tb_switch_debouncer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/switch_debouncer_pkg.sv
// Shared types and constants for the switch debouncer.
// Board and simulation debounce lengths live here.
package switch_debouncer_pkg;

    typedef enum logic [1:0] {
        STABLE_LO,
        WAIT_HI,
        STABLE_HI,
        WAIT_LO
    } db_state_t;

    localparam int DEBOUNCE_CYCLES_BOARD = 1_000_000;
    localparam int DEBOUNCE_CYCLES_SIM   = 4;

endpackage

// File: rtl/debounce_channel.sv
// One switch channel: 2-flop synchroniser, stability counter and FSM.
// Clean level and strobes are all registered.
module debounce_channel
    import switch_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_BOARD,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_sw,
    output logic o_clean,
    output logic o_rise,
    output logic o_fall
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic             r_sync1;
    logic             r_sync2;
    db_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_clean;
    logic             r_rise;
    logic             r_fall;

    db_state_t        w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_clean_nxt;
    logic             w_rise_nxt;
    logic             w_fall_nxt;
    logic             w_s;

    assign w_s = r_sync2;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_sw;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= STABLE_LO;
            r_cnt   <= '0;
            r_clean <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_clean <= w_clean_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
        end
    end

    // The terminal compare forces the exit, so the counter never wraps.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        unique case (r_state)
            STABLE_LO: begin
                if (w_s) begin
                    w_state_nxt = WAIT_HI;
                    w_cnt_nxt   = ONE;
                end
            end
            WAIT_HI: begin
                if (!w_s) begin
                    w_state_nxt = STABLE_LO;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == LAST) begin
                    w_state_nxt = STABLE_HI;
                    w_cnt_nxt   = '0;
                    w_rise_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + ONE;
                end
            end
            STABLE_HI: begin
                if (!w_s) begin
                    w_state_nxt = WAIT_LO;
                    w_cnt_nxt   = ONE;
                end
            end
            WAIT_LO: begin
                if (w_s) begin
                    w_state_nxt = STABLE_HI;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == LAST) begin
                    w_state_nxt = STABLE_LO;
                    w_cnt_nxt   = '0;
                    w_fall_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + ONE;
                end
            end
            default: begin
                w_state_nxt = STABLE_LO;
                w_cnt_nxt   = '0;
            end
        endcase
        w_clean_nxt = (w_state_nxt == STABLE_HI) || (w_state_nxt == WAIT_LO);
    end

    assign o_clean = r_clean;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/switch_debouncer.sv
// N-channel slide-switch debouncer with clean levels and edge strobes.
// Channels are independent copies of debounce_channel.
module switch_debouncer
    import switch_debouncer_pkg::*;
#(
    parameter int N_CH            = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_BOARD,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic            I_P_CLK,
    input  logic            I_P_RST_N,
    input  logic [N_CH-1:0] I_P_SW,
    output logic [N_CH-1:0] O_P_SW_CLEAN,
    output logic [N_CH-1:0] O_P_RISE,
    output logic [N_CH-1:0] O_P_FALL
);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_ch (
            .i_clk  (I_P_CLK),
            .i_rst_n(I_P_RST_N),
            .i_sw   (I_P_SW[g]),
            .o_clean(O_P_SW_CLEAN[g]),
            .o_rise (O_P_RISE[g]),
            .o_fall (O_P_FALL[g])
        );
    end

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer: directed scenarios plus random switching
// compared every cycle against a run-length reference model.
module tb_switch_debouncer;
    import switch_debouncer_pkg::*;

    localparam int N = 2;
    localparam int D = DEBOUNCE_CYCLES_SIM;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] sw    = '0;
    logic [N-1:0] clean;
    logic [N-1:0] rise;
    logic [N-1:0] fall;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model: clean flips once the synced input has disagreed with it
    // for D consecutive samples.
    bit           m_s1[N];
    bit           m_s2[N];
    int           m_run[N];
    logic [N-1:0] m_clean = '0;
    logic [N-1:0] m_rise  = '0;
    logic [N-1:0] m_fall  = '0;

    always #5 clk = ~clk;

    switch_debouncer #(
        .N_CH           (N),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .I_P_CLK     (clk),
        .I_P_RST_N   (rst_n),
        .I_P_SW      (sw),
        .O_P_SW_CLEAN(clean),
        .O_P_RISE    (rise),
        .O_P_FALL    (fall)
    );

    task automatic chk(string name, logic [N-1:0] act, logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        bit s;
        if (!rst_n) begin
            for (int c = 0; c < N; c++) begin
                m_s1[c]  = 1'b0;
                m_s2[c]  = 1'b0;
                m_run[c] = 0;
            end
            m_clean = '0;
            m_rise  = '0;
            m_fall  = '0;
        end else begin
            for (int c = 0; c < N; c++) begin
                s = m_s2[c];
                m_rise[c] = 1'b0;
                m_fall[c] = 1'b0;
                if (s != m_clean[c]) begin
                    m_run[c]++;
                    if (m_run[c] == D) begin
                        m_clean[c] = s;
                        if (s) m_rise[c] = 1'b1;
                        else   m_fall[c] = 1'b1;
                        m_run[c] = 0;
                    end
                end else begin
                    m_run[c] = 0;
                end
                m_s2[c] = m_s1[c];
                m_s1[c] = sw[c];
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_clean", clean, m_clean);
            chk("model_rise",  rise,  m_rise);
            chk("model_fall",  fall,  m_fall);
        end
    end

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int hold[N];
    bit b[4];

    initial begin
        b = '{1'b1, 1'b0, 1'b1, 1'b0};

        // 1: reset then idle
        cyc(1);
        chk_en = 1'b1;
        cyc(2);
        chk("rst_clean", clean, '0);
        chk("rst_strobe", rise | fall, '0);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            chk("idle_out", clean | rise | fall, '0);
        end

        // 2: single step on ch0
        @(negedge clk) sw[0] = 1'b1;
        cyc(5);
        chk("step_pre", clean, 2'b00);
        cyc(1);
        chk("step_clean", clean, 2'b01);
        chk("step_rise", rise, 2'b01);
        cyc(1);
        chk("step_rise_off", rise, 2'b00);
        chk("step_hold", clean, 2'b01);
        @(negedge clk) sw[0] = 1'b0;
        cyc(6);
        chk("step_fall", fall, 2'b01);
        chk("step_lo", clean, 2'b00);
        cyc(3);

        // 3: bounce then settle high
        for (int i = 0; i < 4; i++) begin
            @(negedge clk) sw[0] = b[i];
            cyc(1);
            chk("bnc_quiet", rise | fall, 2'b00);
        end
        @(negedge clk) sw[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc(1);
            chk("bnc_wait", rise, 2'b00);
        end
        cyc(1);
        chk("bnc_rise", rise, 2'b01);
        @(negedge clk) sw[0] = 1'b0;
        cyc(10);

        // 4: 3-cycle glitch on ch1
        @(negedge clk) sw[1] = 1'b1;
        cyc(3);
        @(negedge clk) sw[1] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            chk("glt_clean", clean, 2'b00);
            chk("glt_strobe", rise | fall, 2'b00);
        end

        // 5: simultaneous steps
        @(negedge clk) sw = 2'b11;
        cyc(6);
        chk("sim_clean", clean, 2'b11);
        chk("sim_rise", rise, 2'b11);
        cyc(4);
        @(negedge clk) sw = 2'b00;
        cyc(6);
        chk("sim_fall", fall, 2'b11);
        chk("sim_lo", clean, 2'b00);
        cyc(3);

        // 6: reset mid-wait
        @(negedge clk) sw[0] = 1'b1;
        cyc(3);
        chk("abrt_quiet", rise, 2'b00);
        @(negedge clk) rst_n = 1'b0;
        cyc(1);
        chk("abrt_rst", clean | rise | fall, 2'b00);
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc(1);
            chk("abrt_wait", rise | clean, 2'b00);
        end
        cyc(1);
        chk("abrt_rise", rise, 2'b01);
        chk("abrt_clean", clean, 2'b01);

        // random switching with rare resets
        @(negedge clk) sw = '0;
        cyc(10);
        for (int c = 0; c < N; c++) hold[c] = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            for (int c = 0; c < N; c++) begin
                if (hold[c] == 0) begin
                    sw[c] = ~sw[c];
                    if ($urandom_range(0, 2) == 0)
                        hold[c] = $urandom_range(6, 15);
                    else
                        hold[c] = $urandom_range(0, 4);
                end else begin
                    hold[c]--;
                end
            end
            rst_n = ($urandom_range(0, 499) != 0);
        end
        @(negedge clk) rst_n = 1'b1;
        cyc(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
